openram_scan_driver: RTL

- Host-side initiator for the test chip's GPIO scan interface: the tester end that drives the chip's clock, scan, load, chip-select and serial-in pins, and collects serial-out.
- Takes a parallel scan packet over a valid/ready request port and shifts it into the chip.
- Sequences the load, execute and capture phases, then shifts the captured result back out.
- Returns the result on a valid/ready response port.
- Used in FPGA testers and in the system-level bench, with a behavioural chip model on the tgt_* pins.

---
 rtl/openram_scan_pkg.sv | 24 ++
 rtl/openram_scan_phase_gen.sv | 28 ++
 rtl/openram_scan_driver.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/openram_scan_pkg.sv
// Shared types and constants for the OpenRAM scan driver: FSM states, target
// clock phases and the request-to-response latency formula.
package openram_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_IN,
    ST_LOAD,
    ST_EXEC,
    ST_CAPT,
    ST_SHIFT_OUT,
    ST_RESP
  } scan_state_e;

  localparam logic PH0 = 1'b0;
  localparam logic PH1 = 1'b1;

  // clk cycles from the accepting edge to rsp_valid: two shifts plus
  // load/exec/capture, each target cycle being two driver clocks.
  function automatic int unsigned scan_latency(input int unsigned scan_len);
    return 2 * (2 * scan_len + 3);
  endfunction

endpackage

// File: rtl/openram_scan_phase_gen.sv
// Target clock generator: tgt_clk toggles at clk/2 while enabled, and
// ph1_end marks the driver edge that closes PH1 (the tgt_out sample point).
module openram_scan_phase_gen
  import openram_scan_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic en,
  output logic tgt_clk,
  output logic ph1_end
);

  logic phase_q, phase_d;

  // Disabling parks the chip clock low so the next enable starts in PH0.
  always_comb begin
    phase_d = en ? ~phase_q : PH0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) phase_q <= PH0;
    else         phase_q <= phase_d;
  end

  assign tgt_clk = phase_q;
  assign ph1_end = en && (phase_q == PH1);

endmodule

// File: rtl/openram_scan_driver.sv
// Host-side scan initiator: shift packet in, load/exec/capture, shift result out.
// Optional compare logic is enabled with `define OPENRAM_SCAN_DRV_CMP_EN.
module openram_scan_driver
  import openram_scan_pkg::*;
#(
  parameter int unsigned SCAN_LEN = 8,
  parameter int unsigned CNT_W    = $clog2(SCAN_LEN + 1)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SCAN_LEN-1:0] req_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [SCAN_LEN-1:0] rsp_data,
  output logic                busy,
`ifdef OPENRAM_SCAN_DRV_CMP_EN
  input  logic [SCAN_LEN-1:0] req_expect,
  input  logic [SCAN_LEN-1:0] req_mask,
  output logic                rsp_mismatch,
  output logic                mismatch_sticky,
  input  logic                clr_sticky,
`endif
  output logic                tgt_clk,
  output logic                tgt_resetn,
  output logic                tgt_scan,
  output logic                tgt_sram_load,
  output logic                tgt_global_csb,
  output logic                tgt_in,
  input  logic                tgt_out
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SCAN_LEN - 1);

  scan_state_e         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SCAN_LEN-1:0] tx_q, tx_d;
  logic [SCAN_LEN-1:0] res_q, res_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                busy_q, busy_d;
  logic                tgt_resetn_q, tgt_resetn_d;
  logic                tgt_scan_q, tgt_scan_d;
  logic                tgt_load_q, tgt_load_d;
  logic                tgt_csb_q, tgt_csb_d;
  logic                tgt_in_q, tgt_in_d;

  logic run, ph1_end, accept;

  assign run    = (state_q != ST_IDLE) && (state_q != ST_RESP);
  assign accept = (state_q == ST_IDLE) && req_valid && req_ready_q;

  openram_scan_phase_gen u_phase (
    .clk     (clk),
    .resetn  (resetn),
    .en      (run),
    .tgt_clk (tgt_clk),
    .ph1_end (ph1_end)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SHIFT_IN;
          tx_d    = req_data;
        end
      end
      ST_SHIFT_IN: begin
        if (ph1_end) begin
          tx_d = {tx_q[SCAN_LEN-2:0], 1'b0};
          if (cnt_q == LAST_BIT) state_d = ST_LOAD;
          else                   cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_LOAD: if (ph1_end) state_d = ST_EXEC;
      ST_EXEC: if (ph1_end) state_d = ST_CAPT;
      ST_CAPT: if (ph1_end) state_d = ST_SHIFT_OUT;
      ST_SHIFT_OUT: begin
        if (ph1_end) begin
          // First bit received walks up to the MSB by the end of the shift.
          res_d = {res_q[SCAN_LEN-2:0], tgt_out};
          if (cnt_q == LAST_BIT) state_d = ST_RESP;
          else                   cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: if (rsp_valid_q && rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;

    // Pin levels are decoded from the next state so they change only on PH0 entry.
    req_ready_d  = (state_d == ST_IDLE);
    rsp_valid_d  = (state_d == ST_RESP);
    busy_d       = (state_d != ST_IDLE);
    tgt_resetn_d = 1'b1;
    tgt_scan_d   = (state_d == ST_SHIFT_IN) || (state_d == ST_SHIFT_OUT);
    tgt_load_d   = (state_d == ST_LOAD);
    tgt_csb_d    = (state_d != ST_EXEC);
    tgt_in_d     = (state_d == ST_SHIFT_IN) && tx_d[SCAN_LEN-1];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      tx_q         <= '0;
      res_q        <= '0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      tgt_resetn_q <= 1'b0;
      tgt_scan_q   <= 1'b0;
      tgt_load_q   <= 1'b0;
      tgt_csb_q    <= 1'b1;
      tgt_in_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tx_q         <= tx_d;
      res_q        <= res_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
      tgt_resetn_q <= tgt_resetn_d;
      tgt_scan_q   <= tgt_scan_d;
      tgt_load_q   <= tgt_load_d;
      tgt_csb_q    <= tgt_csb_d;
      tgt_in_q     <= tgt_in_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = res_q;
  assign busy           = busy_q;
  assign tgt_resetn     = tgt_resetn_q;
  assign tgt_scan       = tgt_scan_q;
  assign tgt_sram_load  = tgt_load_q;
  assign tgt_global_csb = tgt_csb_q;
  assign tgt_in         = tgt_in_q;

`ifdef OPENRAM_SCAN_DRV_CMP_EN
  logic [SCAN_LEN-1:0] exp_q, exp_d, mask_q, mask_d;
  logic                sticky_q, sticky_d;
  logic                mism;

  always_comb begin
    exp_d  = exp_q;
    mask_d = mask_q;
    if (accept) begin
      exp_d  = req_expect;
      mask_d = req_mask;
    end
    mism     = |((res_q ^ exp_q) & mask_q);
    sticky_d = sticky_q;
    if (clr_sticky)          sticky_d = 1'b0;
    if (rsp_valid_q && mism) sticky_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exp_q    <= '0;
      mask_q   <= '0;
      sticky_q <= 1'b0;
    end else begin
      exp_q    <= exp_d;
      mask_q   <= mask_d;
      sticky_q <= sticky_d;
    end
  end

  assign rsp_mismatch    = rsp_valid_q && mism;
  assign mismatch_sticky = sticky_q;
`endif

endmodule
